// File: rtl/branch_predict_unit_if.sv
// Bundle of the IF-stage lookup and EX-stage resolve signals of the branch predictor.
// The slave side is the predictor; the master side is the pipeline that drives it.
interface branch_predict_unit_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);

  logic [PC_W-1:0]  if_pc;
  logic             if_pred_taken;

  logic             ex_valid;
  logic             ex_branch;
  logic [2:0]       ex_func3;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic             zero;
  logic             alu_out;

  logic             PCSrc;
  logic             mispredict;
  logic             illegal_branch;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output if_pc,
    input  if_pred_taken,
    output ex_valid,
    output ex_branch,
    output ex_func3,
    output ex_pc,
    output ex_pred_taken,
    output zero,
    output alu_out,
    input  PCSrc,
    input  mispredict,
    input  illegal_branch,
    input  br_count,
    input  mp_count
  );

  modport slave (
    input  if_pc,
    output if_pred_taken,
    input  ex_valid,
    input  ex_branch,
    input  ex_func3,
    input  ex_pc,
    input  ex_pred_taken,
    input  zero,
    input  alu_out,
    output PCSrc,
    output mispredict,
    output illegal_branch,
    output br_count,
    output mp_count
  );

endinterface

// File: rtl/branch_predict_unit.sv
// RV32I conditional-branch resolver with a direct-mapped table of 2-bit saturating
// counters for IF prediction, misprediction flagging and saturating statistics.
module branch_predict_unit #(
  parameter int PC_W        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_unit_if.slave  bpu
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;

  logic             sel;
  logic             legal;
  logic             taken;
  logic             res;
  logic             pc_src;
  logic             mp_flag;
  logic             illegal;

  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;

  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] mp_q;

  logic             unused_pc_bits;

  assign if_idx = bpu.if_pc[IDX_LSB +: IDX_W];
  assign ex_idx = bpu.ex_pc[IDX_LSB +: IDX_W];

  // Bits outside the index window are deliberately ignored, so aliasing PCs share an entry.
  assign unused_pc_bits = ^{bpu.if_pc, bpu.ex_pc};

  // Read port has no bypass: a same-cycle EX write is seen by IF only on the next cycle.
  assign bpu.if_pred_taken = bht[if_idx][1];

  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (bpu.ex_func3)
      F3_BEQ:  taken = bpu.zero;
      F3_BNE:  taken = ~bpu.zero;
      F3_BLT,
      F3_BLTU: taken = bpu.alu_out;
      F3_BGE,
      F3_BGEU: taken = ~bpu.alu_out;
      default: legal = 1'b0;
    endcase

    sel     = bpu.ex_valid & bpu.ex_branch;
    res     = sel & legal;
    pc_src  = res & taken;
    mp_flag = res & (taken != bpu.ex_pred_taken);
    illegal = sel & ~legal;
  end

  assign bpu.PCSrc          = pc_src;
  assign bpu.mispredict     = mp_flag;
  assign bpu.illegal_branch = illegal;

  always_comb begin
    ctr_cur = bht[ex_idx];
    ctr_nxt = ctr_cur;
    if (taken) begin
      if (ctr_cur != CTR_STRONG_T) begin
        ctr_nxt = ctr_cur + 2'd1;
      end
    end else begin
      if (ctr_cur != CTR_STRONG_NT) begin
        ctr_nxt = ctr_cur - 2'd1;
      end
    end
  end

  // Reset takes priority over a branch resolving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_WEAK_NT;
      end
    end else if (res) begin
      bht[ex_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (res && (br_q != {CNT_W{1'b1}})) begin
        br_q <= br_q + CNT_W'(1);
      end
      if (mp_flag && (mp_q != {CNT_W{1'b1}})) begin
        mp_q <= mp_q + CNT_W'(1);
      end
    end
  end

  assign bpu.br_count = br_q;
  assign bpu.mp_count = mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed steps plus randomized traffic
// compared against a reference model built from operand values and counter rules.
module tb_branch_predict_unit;

  localparam int ENTRIES  = 64;
  localparam int ENTRIES2 = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  int checks   = 0;
  int failures = 0;

  int     model_bht [ENTRIES];
  longint model_br;
  longint model_mp;
  int     model2_bht [ENTRIES2];
  int     model2_br;
  int     model2_mp;

  bit last_pcsrc;
  bit last_mispredict;
  bit last_illegal;
  bit last_pred;

  branch_predict_unit_if #(.PC_W(32), .CNT_W(32)) bus1 ();
  branch_predict_unit_if #(.PC_W(32), .CNT_W(4))  bus2 ();

  branch_predict_unit #(
    .PC_W(32), .BHT_ENTRIES(ENTRIES), .IDX_LSB(2), .CNT_W(32)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bpu(bus1.slave)
  );

  branch_predict_unit #(
    .PC_W(32), .BHT_ENTRIES(ENTRIES2), .IDX_LSB(2), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .bpu(bus2.slave)
  );

  always #5 clk = ~clk;

  function automatic bit ref_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  // Branch outcome from the real operand values, not from the zero/less-than flags.
  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_idx(input logic [31:0] pc, input int entries);
    return int'((pc >> 2) % 32'(entries));
  endfunction

  function automatic int sat_step(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model_bht[i] = 1;
    model_br = 0;
    model_mp = 0;
  endtask

  // Called at a falling edge; drives one cycle, checks combinational outputs, then state.
  task automatic apply_stimulus(input string tag, input bit rst_v, input bit valid,
                                input bit branch, input logic [2:0] f3,
                                input logic [31:0] pc, input bit pred,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ipc);
    bit tk, res, exp_pcsrc, exp_mp, exp_ill;
    int ix;
    rst_n               = rst_v;
    bus1.ex_valid       = valid;
    bus1.ex_branch      = branch;
    bus1.ex_func3       = f3;
    bus1.ex_pc          = pc;
    bus1.ex_pred_taken  = pred;
    bus1.zero           = (a == b);
    bus1.alu_out        = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    bus1.if_pc          = ipc;
    tk        = ref_taken(f3, a, b);
    res       = valid && branch && ref_legal(f3);
    exp_pcsrc = res && tk;
    exp_mp    = res && (tk != pred);
    exp_ill   = valid && branch && !ref_legal(f3);
    #1;
    last_pcsrc      = bus1.PCSrc;
    last_mispredict = bus1.mispredict;
    last_illegal    = bus1.illegal_branch;
    last_pred       = bus1.if_pred_taken;
    check_output({tag, ".pcsrc"},      32'(bus1.PCSrc),          32'(exp_pcsrc));
    check_output({tag, ".mispredict"}, 32'(bus1.mispredict),     32'(exp_mp));
    check_output({tag, ".illegal"},    32'(bus1.illegal_branch), 32'(exp_ill));
    check_output({tag, ".pred_pre"},   32'(bus1.if_pred_taken),
                 32'(model_bht[ref_idx(ipc, ENTRIES)] >= 2));
    @(posedge clk);
    if (!rst_v) begin
      model_reset();
    end else if (res) begin
      ix = ref_idx(pc, ENTRIES);
      model_bht[ix] = sat_step(model_bht[ix], tk);
      if (model_br < 64'hffff_ffff) model_br++;
      if (exp_mp && model_mp < 64'hffff_ffff) model_mp++;
    end
    @(negedge clk);
    check_output({tag, ".br_count"},  bus1.br_count, 32'(model_br));
    check_output({tag, ".mp_count"},  bus1.mp_count, 32'(model_mp));
    check_output({tag, ".pred_post"}, 32'(bus1.if_pred_taken),
                 32'(model_bht[ref_idx(ipc, ENTRIES)] >= 2));
  endtask

  initial begin
    logic [31:0] r_pc, r_a, r_b, r_ipc;
    int ix2;

    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus1.if_pc = '0; bus1.ex_valid = 1'b0; bus1.ex_branch = 1'b0; bus1.ex_func3 = '0;
    bus1.ex_pc = '0; bus1.ex_pred_taken = 1'b0; bus1.zero = 1'b0; bus1.alu_out = 1'b0;
    bus2.if_pc = '0; bus2.ex_valid = 1'b0; bus2.ex_branch = 1'b0; bus2.ex_func3 = '0;
    bus2.ex_pc = '0; bus2.ex_pred_taken = 1'b0; bus2.zero = 1'b0; bus2.alu_out = 1'b0;
    model_reset();
    for (int i = 0; i < ENTRIES2; i++) model2_bht[i] = 1;
    model2_br = 0;
    model2_mp = 0;

    @(negedge clk);
    apply_stimulus("rst0", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply_stimulus("rst1", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    for (int i = 0; i < ENTRIES; i++) begin
      bus1.if_pc = 32'(i) << 2;
      #1;
      check_output("sweep_after_reset", 32'(bus1.if_pred_taken), 32'h0);
    end
    @(negedge clk);
    check_output("reset_br", bus1.br_count, 32'h0);
    check_output("reset_mp", bus1.mp_count, 32'h0);

    for (int k = 0; k < 3; k++) begin
      apply_stimulus("beq", 1'b1, 1'b1, 1'b1, 3'b000, 32'h100, 1'b0, 32'd5, 32'd5, 32'h100);
      check_output("beq_pcsrc", 32'(last_pcsrc), 32'h1);
      check_output("beq_mispredict", 32'(last_mispredict), 32'h1);
      check_output("beq_pred_after", 32'(bus1.if_pred_taken), 32'h1);
    end
    check_output("beq_br3", bus1.br_count, 32'd3);
    check_output("beq_mp3", bus1.mp_count, 32'd3);

    apply_stimulus("bltu", 1'b1, 1'b1, 1'b1, 3'b110, 32'h300, 1'b1, 32'd1, 32'd2, 32'h0);
    check_output("bltu_pcsrc", 32'(last_pcsrc), 32'h1);
    apply_stimulus("bgeu", 1'b1, 1'b1, 1'b1, 3'b111, 32'h304, 1'b0, 32'd1, 32'd2, 32'h0);
    check_output("bgeu_pcsrc", 32'(last_pcsrc), 32'h0);
    apply_stimulus("bne", 1'b1, 1'b1, 1'b1, 3'b001, 32'h308, 1'b1, 32'd3, 32'd4, 32'h0);
    check_output("bne_pcsrc", 32'(last_pcsrc), 32'h1);
    apply_stimulus("blt_neg", 1'b1, 1'b1, 1'b1, 3'b100, 32'h30c, 1'b1,
                   32'hffff_fff0, 32'd4, 32'h0);
    check_output("blt_neg_pcsrc", 32'(last_pcsrc), 32'h1);

    apply_stimulus("illegal", 1'b1, 1'b1, 1'b1, 3'b010, 32'h100, 1'b1, 32'd5, 32'd5, 32'h100);
    check_output("illegal_flag", 32'(last_illegal), 32'h1);
    check_output("illegal_pcsrc", 32'(last_pcsrc), 32'h0);
    check_output("illegal_br", bus1.br_count, 32'd7);
    check_output("illegal_mp", bus1.mp_count, 32'd3);
    apply_stimulus("novalid", 1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 1'b1, 32'd5, 32'd5, 32'h100);
    check_output("novalid_illegal", 32'(last_illegal), 32'h0);
    check_output("novalid_mispredict", 32'(last_mispredict), 32'h0);
    apply_stimulus("nobranch", 1'b1, 1'b1, 1'b0, 3'b000, 32'h100, 1'b0, 32'd5, 32'd5, 32'h100);
    check_output("nobranch_pcsrc", 32'(last_pcsrc), 32'h0);

    apply_stimulus("rst2", 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    apply_stimulus("same_idx", 1'b1, 1'b1, 1'b1, 3'b000, 32'h200, 1'b0, 32'd7, 32'd7, 32'h200);
    check_output("same_idx_old", 32'(last_pred), 32'h0);
    check_output("same_idx_new", 32'(bus1.if_pred_taken), 32'h1);
    apply_stimulus("rst_wins", 1'b0, 1'b1, 1'b1, 3'b000, 32'h200, 1'b0, 32'd7, 32'd7, 32'h200);
    check_output("rst_wins_pred", 32'(bus1.if_pred_taken), 32'h0);
    check_output("rst_wins_br", bus1.br_count, 32'h0);

    for (int n = 0; n < 400; n++) begin
      r_pc  = $urandom & 32'hffff_fffc;
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
      r_ipc = ($urandom_range(0, 1) == 0) ? r_pc : ($urandom & 32'hffff_fffc);
      apply_stimulus("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), r_pc,
                     1'($urandom_range(0, 1)), r_a, r_b, r_ipc);
    end

    // Small-counter instance: taken branches all predicted not-taken.
    for (int k = 0; k < 20; k++) begin
      r_pc = 32'($urandom_range(0, ENTRIES2 - 1)) << 2;
      bus2.ex_valid = 1'b1; bus2.ex_branch = 1'b1; bus2.ex_func3 = 3'b000;
      bus2.ex_pc = r_pc; bus2.ex_pred_taken = 1'b0; bus2.zero = 1'b1;
      bus2.alu_out = 1'($urandom_range(0, 1));
      #1;
      check_output("sat_pcsrc", 32'(bus2.PCSrc), 32'h1);
      check_output("sat_mispredict", 32'(bus2.mispredict), 32'h1);
      @(posedge clk);
      ix2 = ref_idx(r_pc, ENTRIES2);
      model2_bht[ix2] = sat_step(model2_bht[ix2], 1'b1);
      if (model2_br < 15) model2_br++;
      if (model2_mp < 15) model2_mp++;
      @(negedge clk);
      check_output("sat_br", 32'(bus2.br_count), 32'(model2_br));
      check_output("sat_mp", 32'(bus2.mp_count), 32'(model2_mp));
    end
    check_output("sat_br15", 32'(bus2.br_count), 32'd15);
    check_output("sat_mp15", 32'(bus2.mp_count), 32'd15);
    bus2.ex_valid = 1'b0;
    for (int i = 0; i < ENTRIES2; i++) begin
      bus2.if_pc = 32'(i) << 2;
      #1;
      check_output("sat_sweep", 32'(bus2.if_pred_taken), 32'(model2_bht[i] >= 2));
    end
    @(negedge clk);

    rst2_n = 1'b0;
    bus2.ex_valid = 1'b1;
    bus2.ex_pc = 32'h4;
    @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    bus2.ex_valid = 1'b0;
    check_output("mid_rst_br", 32'(bus2.br_count), 32'h0);
    check_output("mid_rst_mp", 32'(bus2.mp_count), 32'h0);
    for (int i = 0; i < ENTRIES2; i++) begin
      bus2.if_pc = 32'(i) << 2;
      #1;
      check_output("mid_rst_sweep", 32'(bus2.if_pred_taken), 32'h0);
    end
    @(negedge clk);
    bus2.ex_valid = 1'b1; bus2.ex_pc = 32'hc; bus2.zero = 1'b1; bus2.if_pc = 32'hc;
    @(posedge clk);
    @(negedge clk);
    bus2.ex_valid = 1'b0;
    #1;
    check_output("weak_nt_one_step", 32'(bus2.if_pred_taken), 32'h1);
    check_output("after_rst_br", 32'(bus2.br_count), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
